// File: rtl/pic_control_seq.sv
// pic_control_seq
//   Four-phase (Q1..Q4) instruction sequencer for the structural PIC core.
//   It holds the current 14-bit instruction and decodes a PIC16 subset.
//   From that decode it drives the W, file-bank, literal-bus, ALU and PC
//   controls, completing one instruction every four clocks.
//
// Ports
//   clock          system clock; all state changes on the rising edge
//   reset          asynchronous, active-high reset
//   prog_data[13:0] program word at the current PC, captured at end of Q4
//   phase[1:0]     0=Q1, 1=Q2, 2=Q3, 3=Q4
//   ir[13:0]       current instruction register
//   file_addr[6:0] ir[6:0]
//   goto_addr[10:0] ir[10:0]
//   lit_out_en, file_read_en, w_out_a_en, w_out_b_en   operand bus enables (Q2-Q3)
//   alu_op[2:0]    0 PASSB, 1 ADD, 2 SUB, 3 AND, 4 IOR, 5 XOR, 6 ZERO (Q3-Q4)
//   w_write_en, file_write_en, pc_load, illegal        Q4 pulses
//   pc_inc         Q1 pulse
//   ir_load        Q4, always asserted (also while flushing)
module pic_control_seq #(
  parameter logic [13:0] RESET_INSTR = 14'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] prog_data,
  output logic [1:0]  phase,
  output logic [13:0] ir,
  output logic [6:0]  file_addr,
  output logic [10:0] goto_addr,
  output logic        lit_out_en,
  output logic        file_read_en,
  output logic        file_write_en,
  output logic        w_out_a_en,
  output logic        w_out_b_en,
  output logic        w_write_en,
  output logic [2:0]  alu_op,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        ir_load,
  output logic        illegal
);

  localparam logic [2:0] ALU_PASSB = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_IOR   = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_ZERO  = 3'd6;

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

  phase_t      phase_q, phase_d;
  logic [13:0] ir_q, ir_d;
  logic        flush_q, flush_d;

  // Registered control outputs
  logic       lit_q, fread_q, fwrite_q, wa_q, wb_q, wwrite_q;
  logic       pcinc_q, pcload_q, irload_q, illegal_q;
  logic [2:0] alu_q;

  // Decode of the instruction that will be in the IR after this edge
  logic       dec_lit, dec_fread, dec_wa, dec_wb, dec_wwr, dec_fwr;
  logic       dec_goto, dec_ill;
  logic [2:0] dec_alu;

  // Next architectural state: the phase counter never stalls, so all
  // outputs can be precomputed from the next phase/IR/flush values.
  always_comb begin
    phase_d = phase_t'(phase_q + 2'd1);
    ir_d    = ir_q;
    flush_d = flush_q;
    if (phase_q == Q4) begin
      ir_d    = prog_data;
      // A GOTO sitting in the IR during a flush is discarded, so it
      // cannot re-arm the flush.
      flush_d = !flush_q && (ir_q[13:11] == 3'b101);
    end
  end

  always_comb begin
    dec_lit   = 1'b0;
    dec_fread = 1'b0;
    dec_wa    = 1'b0;
    dec_wb    = 1'b0;
    dec_wwr   = 1'b0;
    dec_fwr   = 1'b0;
    dec_goto  = 1'b0;
    dec_ill   = 1'b0;
    dec_alu   = ALU_PASSB;
    case (ir_d[13:12])
      2'b00: begin
        case (ir_d[11:8])
          4'h0: begin
            if (ir_d[7]) begin            // MOVWF
              dec_wb  = 1'b1;
              dec_fwr = 1'b1;
            end else if (ir_d[4:0] != 5'd0) begin
              dec_ill = 1'b1;             // not a NOP form
            end
          end
          4'h1: begin
            if (ir_d[7]) begin            // CLRF
              dec_alu = ALU_ZERO;
              dec_fwr = 1'b1;
            end else begin
              dec_ill = 1'b1;
            end
          end
          4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            // Byte ops: read f, destination selected by d = ir[7]
            dec_fread = 1'b1;
            dec_wa    = (ir_d[11:8] != 4'h8);   // MOVF does not read W
            dec_wwr   = !ir_d[7];
            dec_fwr   = ir_d[7];
            case (ir_d[11:8])
              4'h2:    dec_alu = ALU_SUB;
              4'h4:    dec_alu = ALU_IOR;
              4'h5:    dec_alu = ALU_AND;
              4'h6:    dec_alu = ALU_XOR;
              4'h7:    dec_alu = ALU_ADD;
              default: dec_alu = ALU_PASSB;
            endcase
          end
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        if (ir_d[11]) dec_goto = 1'b1;
        else          dec_ill  = 1'b1;
      end
      2'b11: begin
        // Literal ops: literal on B, result to W
        dec_lit = 1'b1;
        dec_wwr = 1'b1;
        dec_wa  = 1'b1;
        casez (ir_d[11:8])
          4'b00??: begin dec_alu = ALU_PASSB; dec_wa = 1'b0; end
          4'b1000: dec_alu = ALU_IOR;
          4'b1001: dec_alu = ALU_AND;
          4'b1010: dec_alu = ALU_XOR;
          4'b110?: dec_alu = ALU_SUB;
          4'b111?: dec_alu = ALU_ADD;
          default: begin
            dec_lit = 1'b0;
            dec_wwr = 1'b0;
            dec_wa  = 1'b0;
            dec_ill = 1'b1;
          end
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  logic run_d, q23_d, q34_d, q4_d;
  assign run_d = !flush_d;
  assign q23_d = (phase_d == Q2) || (phase_d == Q3);
  assign q34_d = (phase_d == Q3) || (phase_d == Q4);
  assign q4_d  = (phase_d == Q4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q   <= Q1;
      ir_q      <= RESET_INSTR;
      flush_q   <= 1'b0;
      lit_q     <= 1'b0;
      fread_q   <= 1'b0;
      fwrite_q  <= 1'b0;
      wa_q      <= 1'b0;
      wb_q      <= 1'b0;
      wwrite_q  <= 1'b0;
      pcinc_q   <= 1'b0;
      pcload_q  <= 1'b0;
      irload_q  <= 1'b0;
      illegal_q <= 1'b0;
      alu_q     <= ALU_PASSB;
    end else begin
      phase_q   <= phase_d;
      ir_q      <= ir_d;
      flush_q   <= flush_d;
      pcinc_q   <= run_d && (phase_d == Q1);
      lit_q     <= run_d && q23_d && dec_lit;
      fread_q   <= run_d && q23_d && dec_fread;
      wa_q      <= run_d && q23_d && dec_wa;
      wb_q      <= run_d && q23_d && dec_wb;
      alu_q     <= (run_d && q34_d) ? dec_alu : ALU_PASSB;
      wwrite_q  <= run_d && q4_d && dec_wwr;
      fwrite_q  <= run_d && q4_d && dec_fwr;
      pcload_q  <= run_d && q4_d && dec_goto;
      illegal_q <= run_d && q4_d && dec_ill;
      irload_q  <= q4_d;
    end
  end

  assign phase         = phase_q;
  assign ir            = ir_q;
  assign file_addr     = ir_q[6:0];
  assign goto_addr     = ir_q[10:0];
  assign lit_out_en    = lit_q;
  assign file_read_en  = fread_q;
  assign file_write_en = fwrite_q;
  assign w_out_a_en    = wa_q;
  assign w_out_b_en    = wb_q;
  assign w_write_en    = wwrite_q;
  assign alu_op        = alu_q;
  assign pc_inc        = pcinc_q;
  assign pc_load       = pcload_q;
  assign ir_load       = irload_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_pic_control_seq.sv
// Directed testbench for pic_control_seq. Each instruction is loaded at the
// end of a Q4 and its four phases are compared against hand-written vectors.
module tb_pic_control_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [13:0] prog_data;
  logic [1:0]  phase;
  logic [13:0] ir;
  logic [6:0]  file_addr;
  logic [10:0] goto_addr;
  logic        lit_out_en, file_read_en, file_write_en;
  logic        w_out_a_en, w_out_b_en, w_write_en;
  logic [2:0]  alu_op;
  logic        pc_inc, pc_load, ir_load, illegal;

  int errors = 0;
  int checks = 0;

  pic_control_seq #(.RESET_INSTR(14'h0000)) dut (
    .clock(clock), .reset(reset), .prog_data(prog_data),
    .phase(phase), .ir(ir), .file_addr(file_addr), .goto_addr(goto_addr),
    .lit_out_en(lit_out_en), .file_read_en(file_read_en),
    .file_write_en(file_write_en), .w_out_a_en(w_out_a_en),
    .w_out_b_en(w_out_b_en), .w_write_en(w_write_en), .alu_op(alu_op),
    .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {pc_inc, lit, fread, wa, wb, alu_op, w_write, f_write, ir_load, pc_load, illegal}
  function automatic logic [12:0] obs();
    return {pc_inc, lit_out_en, file_read_en, w_out_a_en, w_out_b_en, alu_op,
            w_write_en, file_write_en, ir_load, pc_load, illegal};
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  // Entered at the negedge of a Q4; leaves at the negedge of the next Q4.
  task automatic exec(input string tag, input logic [13:0] instr, input logic pinc,
                      input logic [3:0] en, input logic [2:0] alu,
                      input logic [1:0] wr, input logic pcl, input logic ill);
    prog_data = instr;
    step();
    check({tag, " ir"}, 32'(ir), 32'(instr));
    check({tag, " Q1"}, 32'({phase, obs()}), 32'({2'd0, pinc, 4'b0, 3'b0, 2'b0, 3'b0}));
    step();
    check({tag, " Q2"}, 32'({phase, obs()}), 32'({2'd1, 1'b0, en, 3'b0, 2'b0, 3'b0}));
    step();
    check({tag, " Q3"}, 32'({phase, obs()}), 32'({2'd2, 1'b0, en, alu, 2'b0, 3'b0}));
    step();
    check({tag, " Q4"}, 32'({phase, obs()}), 32'({2'd3, 1'b0, 4'b0, alu, wr, 1'b1, pcl, ill}));
    $display("instr %s ir=%04h done (checks=%0d errors=%0d)", tag, instr, checks, errors);
  endtask

  initial begin
    reset     = 1'b1;
    prog_data = 14'h0000;
    step();
    step();
    check("rst vec", 32'({phase, obs()}), 32'd0);
    check("rst ir", 32'(ir), 32'd0);
    reset = 1'b0;
    check("post-rel Q1", 32'({phase, obs()}), 32'd0);
    step();
    check("nop Q2", 32'({phase, obs()}), 32'({2'd1, 13'd0}));
    step();
    step();
    check("nop Q4", 32'({phase, obs()}), 32'({2'd3, 10'd0, 1'b1, 2'b0}));
    $display("reset/nop sequence done (checks=%0d errors=%0d)", checks, errors);

    //    tag        instr     pinc en(l,f,a,b) alu   wr(w,f) pcl ill
    exec("MOVLW",    14'h305A, 1'b1, 4'b1000, 3'd0, 2'b10, 1'b0, 1'b0);
    exec("ADDWF,0",  14'h0721, 1'b1, 4'b0110, 3'd1, 2'b10, 1'b0, 1'b0);
    check("ADDWF faddr", 32'(file_addr), 32'h21);
    exec("MOVWF",    14'h008C, 1'b1, 4'b0001, 3'd0, 2'b01, 1'b0, 1'b0);
    exec("CLRF",     14'h0185, 1'b1, 4'b0000, 3'd6, 2'b01, 1'b0, 1'b0);
    exec("XORWF,1",  14'h06A1, 1'b1, 4'b0110, 3'd5, 2'b01, 1'b0, 1'b0);
    exec("MOVF,0",   14'h0821, 1'b1, 4'b0100, 3'd0, 2'b10, 1'b0, 1'b0);
    exec("SUBLW",    14'h3C10, 1'b1, 4'b1010, 3'd2, 2'b10, 1'b0, 1'b0);
    exec("GOTO",     14'h2923, 1'b1, 4'b0000, 3'd0, 2'b00, 1'b1, 1'b0);
    check("GOTO addr", 32'(goto_addr), 32'h123);
    exec("flushMOVLW", 14'h305A, 1'b0, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
    exec("ILL0E00",  14'h0E00, 1'b1, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b1);
    exec("NOP0060",  14'h0060, 1'b1, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
    exec("ILL0001",  14'h0001, 1'b1, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b1);
    exec("GOTO2",    14'h2805, 1'b1, 4'b0000, 3'd0, 2'b00, 1'b1, 1'b0);
    exec("flushGOTO", 14'h2FFF, 1'b0, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
    exec("ANDLW",    14'h390F, 1'b1, 4'b1010, 3'd3, 2'b10, 1'b0, 1'b0);

    // Reset in the middle of Q3 of ADDWF 0x21,1
    prog_data = 14'h07A1;
    step();
    step();
    step();
    check("ADDWF,1 Q3", 32'({phase, file_read_en, w_out_a_en, alu_op}), 32'({2'd2, 1'b1, 1'b1, 3'd1}));
    #2;
    reset = 1'b1;
    #1;
    check("midrst vec", 32'({phase, obs()}), 32'd0);
    @(posedge clock);
    #1;
    check("midrst fwr", 32'({file_write_en, w_write_en, obs()}), 32'd0);
    step();
    reset = 1'b0;
    check("rel phase", 32'({phase, obs()}), 32'd0);
    step();
    check("rel Q2", 32'({phase, obs(), ir}), 32'({2'd1, 13'd0, 14'h0000}));
    $display("mid-instruction reset done (checks=%0d errors=%0d)", checks, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
